// File: rtl/t20_timer_if.sv
// ============================================================================
// Module      : t20_timer_if
// Description : 20-minute timer handshake bundle between controller and timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface t20_timer_if;
   logic       T20START;
   logic       PAUSE;
   logic       T20DONE;
   logic       BUSY;
   logic [6:0] REMAIN_MIN;
   logic [5:0] REMAIN_SEC;

   modport master (
      output T20START, PAUSE,
      input  T20DONE, BUSY, REMAIN_MIN, REMAIN_SEC
   );

   modport slave (
      input  T20START, PAUSE,
      output T20DONE, BUSY, REMAIN_MIN, REMAIN_SEC
   );
endinterface

`default_nettype wire

// File: rtl/t20_timer.sv
// ============================================================================
// Module      : t20_timer
// Description : Responder for the controller's T20START/T20DONE interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t20_timer #(
   parameter int TICKS_PER_SEC = 1,
   parameter int DURATION_SEC  = 1200
) (
   input  wire logic  CLOCK,
   input  wire logic  nRESET,
   t20_timer_if.slave bus
);

   localparam int             c_PRESC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam [c_PRESC_W-1:0] c_PRESC_MAX  = c_PRESC_W'(TICKS_PER_SEC - 1);
   localparam [6:0]           c_RELOAD_MIN = 7'(DURATION_SEC / 60);
   localparam [5:0]           c_RELOAD_SEC = 6'(DURATION_SEC % 60);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_PRESC_W-1:0] r_presc;
   logic [6:0]           r_min;
   logic [5:0]           r_sec;
   logic                 r_done;
   logic                 r_busy;

   // Only 00:01 can decrement to 00:00, so that is the final-second test.
   logic w_last_sec;
   assign w_last_sec = (r_min == 7'd0) && (r_sec == 6'd1);

   always_ff @(negedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_min   <= c_RELOAD_MIN;
         r_sec   <= c_RELOAD_SEC;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_min   <= c_RELOAD_MIN;
               r_sec   <= c_RELOAD_SEC;
               r_presc <= '0;
               if (bus.T20START) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (!bus.T20START) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_presc <= '0;
                  r_min   <= c_RELOAD_MIN;
                  r_sec   <= c_RELOAD_SEC;
               end else if (!bus.PAUSE) begin
                  if (r_presc == c_PRESC_MAX) begin
                     r_presc <= '0;
                     if (r_sec != 6'd0) begin
                        r_sec <= r_sec - 6'd1;
                     end else begin
                        r_sec <= 6'd59;
                        r_min <= r_min - 7'd1;
                     end
                     if (w_last_sec) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_presc <= r_presc + 1'b1;
                  end
               end
            end
            S_DONE: begin
               // Holding T20START never restarts; the controller must drop it to re-arm.
               if (!bus.T20START) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
                  r_min   <= c_RELOAD_MIN;
                  r_sec   <= c_RELOAD_SEC;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.T20DONE    = r_done;
   assign bus.BUSY       = r_busy;
   assign bus.REMAIN_MIN = r_min;
   assign bus.REMAIN_SEC = r_sec;

endmodule

`default_nettype wire

// File: tb/tb_t20_timer.sv
// ============================================================================
// Module      : tb_t20_timer
// Description : Self-checking bench for t20_timer (4 tick/3 s and default configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t20_timer;

   logic CLOCK;
   logic nRESET;
   logic s_start;
   logic s_pause;

   t20_timer_if if_a ();
   t20_timer_if if_b ();

   assign if_a.T20START = s_start;
   assign if_a.PAUSE    = s_pause;
   assign if_b.T20START = s_start;
   assign if_b.PAUSE    = s_pause;

   t20_timer #(.TICKS_PER_SEC(4), .DURATION_SEC(3)) u_dut_a (
      .CLOCK  (CLOCK),
      .nRESET (nRESET),
      .bus    (if_a)
   );

   t20_timer #(.TICKS_PER_SEC(1), .DURATION_SEC(1200)) u_dut_b (
      .CLOCK  (CLOCK),
      .nRESET (nRESET),
      .bus    (if_b)
   );

   initial CLOCK = 1'b1;
   always #5 CLOCK = ~CLOCK;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: mode 0=idle 1=running 2=done, el = non-paused edges since entry.
   int c_ticks [2] = '{4, 1};
   int c_dur   [2] = '{3, 1200};
   int m_mode  [2];
   int m_el    [2];

   function automatic logic [14:0] pack_exp(input bit d, input bit b, input int rem);
      return {d, b, 7'(rem / 60), 6'(rem % 60)};
   endfunction

   function automatic logic [14:0] model_exp(input int k);
      int rem;
      if (m_mode[k] == 2)      rem = 0;
      else if (m_mode[k] == 0) rem = c_dur[k];
      else                     rem = c_dur[k] - m_el[k] / c_ticks[k];
      return pack_exp(m_mode[k] == 2, m_mode[k] == 1, rem);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         m_el[k]   = 0;
      end
   endfunction

   function automatic void model_edge(input logic s, input logic p);
      for (int k = 0; k < 2; k++) begin
         case (m_mode[k])
            0: if (s) begin m_mode[k] = 1; m_el[k] = 0; end
            1: begin
               if (!s) m_mode[k] = 0;
               else if (!p) begin
                  m_el[k]++;
                  if (m_el[k] == c_dur[k] * c_ticks[k]) m_mode[k] = 2;
               end
            end
            default: if (!s) m_mode[k] = 0;
         endcase
      end
   endfunction

   function automatic logic [14:0] act(input int k);
      if (k == 0) return {if_a.T20DONE, if_a.BUSY, if_a.REMAIN_MIN, if_a.REMAIN_SEC};
      return {if_b.T20DONE, if_b.BUSY, if_b.REMAIN_MIN, if_b.REMAIN_SEC};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_model(input string name);
      check({name, "/A"}, 32'(act(0)), 32'(model_exp(0)));
      check({name, "/B"}, 32'(act(1)), 32'(model_exp(1)));
   endtask

   // Called #1 after a falling edge; applies inputs for the next falling edge.
   task automatic step(input logic s, input logic p);
      s_start = s;
      s_pause = p;
      @(negedge CLOCK);
      #1;
      model_edge(s, p);
   endtask

   task automatic async_reset();
      #2 nRESET = 1'b0;
      #1;
      model_reset();
      check("async_reset", 32'(act(0)), 32'(pack_exp(0, 0, 3)));
      check("async_reset_b", 32'(act(1)), 32'(pack_exp(0, 0, 1200)));
      #2 nRESET = 1'b1;
   endtask

   typedef struct {
      logic        s;
      logic        p;
      logic [14:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic s, input logic p, input bit d, input bit b, input int rem);
      vec_t v;
      v.s   = s;
      v.p   = p;
      v.exp = pack_exp(d, b, rem);
      tbl.push_back(v);
   endfunction

   initial begin
      int first_done;
      nRESET  = 1'b0;
      s_start = 1'b0;
      s_pause = 1'b0;
      model_reset();
      @(negedge CLOCK);
      @(negedge CLOCK);
      #1;
      check("reset_a", 32'(act(0)), 32'(pack_exp(0, 0, 3)));
      check("reset_b", 32'(act(1)), 32'(pack_exp(0, 0, 1200)));
      nRESET = 1'b1;

      // Table: entry, pause, abort after 4 counted edges, full run, hold, re-arm.
      add(0, 0, 0, 0, 3);
      add(1, 0, 0, 1, 3);
      add(1, 1, 0, 1, 3);
      for (int i = 1; i <= 3; i++) add(1, 0, 0, 1, 3);
      add(1, 0, 0, 1, 2);
      add(0, 0, 0, 0, 3);
      add(0, 1, 0, 0, 3);
      add(1, 0, 0, 1, 3);
      for (int el = 1; el <= 12; el++) begin
         if (el == 12) add(1, 0, 1, 0, 0);
         else          add(1, 0, 0, 1, 3 - el / 4);
      end
      add(1, 1, 1, 0, 0);
      add(0, 0, 0, 0, 3);
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].p);
         check($sformatf("tbl[%0d]", i), 32'(act(0)), 32'(tbl[i].exp));
      end

      // Pause for 5 edges mid-run: done lands on edge 17 after entry.
      step(1, 0);
      check_model("pause_entry");
      first_done = -1;
      for (int i = 1; i <= 22; i++) begin
         step(1, (i >= 3 && i <= 7));
         check_model("pause_run");
         if (first_done < 0 && if_a.T20DONE) first_done = i;
      end
      check("pause_latency", 32'(first_done), 32'd17);

      // Hold in DONE (already held past it above), then re-arm.
      for (int i = 0; i < 10; i++) begin
         step(1, i[0]);
         check_model("done_hold");
      end
      step(0, 0);
      check_model("rearm_drop");
      step(1, 0);
      check_model("rearm_start");

      // Async reset between edges mid-run.
      for (int i = 0; i < 5; i++) step(1, 0);
      async_reset();
      check_model("post_reset");

      // Abort on the final-tick edge: no T20DONE.
      step(1, 0);
      for (int i = 1; i <= 11; i++) step(1, 0);
      check_model("pre_final");
      step(0, 0);
      check("abort_final", 32'(act(0)), 32'(pack_exp(0, 0, 3)));
      step(0, 0);
      check_model("abort_final_idle");

      // Default config: 18:59 after 61 edges, done after exactly 1200.
      step(1, 0);
      check("b_entry", 32'(act(1)), 32'(pack_exp(0, 1, 1200)));
      for (int i = 1; i <= 1200; i++) begin
         step(1, 0);
         if (i == 61)   check("b_1859", 32'(act(1)), 32'(pack_exp(0, 1, 18 * 60 + 59)));
         if (i == 1199) check("b_pre_done", 32'(act(1)), 32'(pack_exp(0, 1, 1)));
      end
      check("b_done", 32'(act(1)), 32'(pack_exp(1, 0, 0)));
      step(0, 0);
      check_model("b_rearm");

      // Randomized stimulus against the reference model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
            check_model("rnd_reset");
         end
         step($urandom_range(0, 99) < 93, $urandom_range(0, 99) < 25);
         check_model("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/t20_timer.md
Name: t20_timer

Overview:
- Responder side of the washing-machine controller's 20-minute timer handshake: accepts T20START from the controller and returns T20DONE once the programmed wash/rinse/dry interval has elapsed.
- Runs on the divided clock, the same net that drives the controller.
- A prescaler turns clock edges into seconds; a minutes/seconds down-counter tracks the interval.
- Remaining time is exported for the seven-segment display path.

Parameters:
TICKS_PER_SEC, 1, CLOCK edges per second (>=1); 1 matches the 1 Hz divided clock.
DURATION_SEC, 1200, interval length in seconds (1..5999, i.e. up to 99:59).

Ports:
CLOCK  input  1  system clock; all state updates on the falling edge.
nRESET  input  1  asynchronous, active-low reset.
T20START  input  1  level request from controller; high = run or hold interval.
PAUSE  input  1  lid-open/hold; freezes counting while high.
T20DONE  output  1  interval elapsed; registered.
BUSY  output  1  high while in RUN state.
REMAIN_MIN  output  7  remaining whole minutes (0..99).
REMAIN_SEC  output  6  remaining seconds within the minute (0..59).

Behaviour:
- State machine: IDLE, RUN, DONE. All registers update on the falling edge of CLOCK.
- Reset (nRESET=0, any time, including mid-interval):
  - state=IDLE, prescaler=0, T20DONE=0, BUSY=0.
  - REMAIN_MIN/REMAIN_SEC = DURATION_SEC/60 and DURATION_SEC%60 (1200 -> 20:00).
- IDLE:
  - Counters are held at the reload value.
  - T20START=1 sampled at edge E -> RUN at E, prescaler=0, BUSY=1 from E.
- RUN, PAUSE=0, per edge:
  - If prescaler==TICKS_PER_SEC-1: prescaler wraps to 0 and one second is decremented.
  - Otherwise: prescaler increments.
- Second decrement:
  - If SEC>0: SEC-1.
  - Else: SEC=59, MIN-1.
- When the decrement yields 00:00: state=DONE on that same edge, T20DONE=1, BUSY=0.
- Run latency: T20DONE rises exactly DURATION_SEC*TICKS_PER_SEC non-paused edges after the RUN entry edge.
- PAUSE=1 in RUN:
  - Prescaler and remaining time hold; BUSY stays 1.
  - Counting resumes on the first edge with PAUSE=0, with no lost or extra tick.
- PAUSE is ignored in IDLE and DONE.
- T20START=0 in RUN (abort):
  - IDLE on that edge, counters reload, BUSY=0.
  - T20DONE is never asserted for an aborted run.
- DONE:
  - T20DONE=1 and REMAIN=00:00 while T20START=1.
  - T20START held high never restarts the interval; the controller must drop T20START to re-arm.
  - T20START=0 -> IDLE on that edge: T20DONE=0, counters reload.
- Simultaneous events:
  - Abort (T20START=0) has priority over PAUSE and over the final decrement: no DONE.
  - PAUSE on the final-tick edge suppresses the tick.
- Outputs are registered and glitch-free. T20DONE and BUSY are never both 1.
- Arithmetic:
  - Prescaler width is clog2(TICKS_PER_SEC), minimum 1.
  - With TICKS_PER_SEC=1 the prescaler is unused and every RUN edge is a second.
  - No wrap below 00:00 is possible.

Test Plan:
1. TICKS_PER_SEC=4, DURATION_SEC=3; reset, then T20START=1 held -> BUSY=1 at the entry edge; T20DONE=1 exactly 12 falling edges later; REMAIN steps 0:03->0:02->0:01->0:00 every 4 edges.
2. Same config; PAUSE=1 for 5 edges mid-run -> REMAIN frozen, T20DONE delayed by exactly 5 edges (17 total).
3. Abort: T20START dropped after 6 edges -> IDLE next edge, REMAIN=0:03, T20DONE stays 0; re-raise T20START -> full 12-edge run again.
4. DONE hold/re-arm: T20START held 10 edges past DONE -> T20DONE stays 1, REMAIN=0:00; T20START=0 -> T20DONE=0 same edge; T20START=1 -> new run.
5. Defaults (1, 1200): reset shows 20:00; after 61 edges shows 18:59; T20DONE after 1200 edges.
6. nRESET pulsed low asynchronously mid-run (between edges) -> outputs immediately at reset values (BUSY=0, T20DONE=0, REMAIN=reload); edge with final tick and T20START=0 simultaneously -> IDLE, no T20DONE pulse.
